tmds_channel_decoder: RTL and testbench

- Receive-side counterpart of the HDMI TMDS encoder path. Decodes one TMDS channel's word-parallel 10-bit symbols back to 8-bit pixel data, 2-bit control and data-enable.
- Acquires symbol alignment by watching control-token runs in blanking. Requests bit slips from the upstream deserializer until aligned.
- Used for loopback capture and on-board self-test of the upscaler/HDMI output at 720x480 (858x525 frame).

---
 rtl/tmds_channel_decoder.sv | 179 +++++++++++++++++
 tb/tb_tmds_channel_decoder.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/tmds_channel_decoder.sv
// tmds_channel_decoder: decodes one TMDS channel to data/ctrl/de and
// acquires symbol alignment from control-token runs, requesting bit slips.
module tmds_channel_decoder #(
  parameter int LOCK_RUN       = 16,
  parameter int SEARCH_TIMEOUT = 2048,
  parameter int SLIP_SETTLE    = 8,
  parameter int ERR_WINDOW     = 1024,
  parameter int ERR_LIMIT      = 8
) (
  input  logic        clk_h,
  input  logic        rst_h,
  input  logic        sym_valid,
  input  logic [9:0]  sym,
  output logic        out_valid,
  output logic [7:0]  data,
  output logic [1:0]  ctrl,
  output logic        de,
  output logic        sym_err,
  output logic        locked,
  output logic        bitslip,
  output logic [15:0] err_count
);
  localparam int RW = $clog2(LOCK_RUN + 1);
  localparam int SW = $clog2(SEARCH_TIMEOUT + 1);
  localparam int TW = $clog2(SLIP_SETTLE + 1);
  localparam int WW = $clog2(ERR_WINDOW + 1);
  localparam int EW = $clog2(ERR_LIMIT + 1);
  localparam logic [RW-1:0] RUN_LAST    = RW'(LOCK_RUN - 1);
  localparam logic [SW-1:0] SEARCH_LAST = SW'(SEARCH_TIMEOUT - 1);
  localparam logic [TW-1:0] SETTLE_LAST = TW'(SLIP_SETTLE - 1);
  localparam logic [WW-1:0] WIN_LAST    = WW'(ERR_WINDOW - 1);
  localparam logic [EW-1:0] ERR_LAST    = EW'(ERR_LIMIT - 1);
  typedef enum logic [1:0] {SEARCH, LOCKED, SLIP} state_t;
  typedef enum logic [1:0] {CLS_DATA, CLS_CTRL, CLS_ERR} cls_t;
  logic [7:0] d_in, byte_in;
  logic       is_ctrl, xnor_req;
  logic [1:0] tok_in;
  cls_t       cls_in;
  always_comb begin
    d_in     = sym[9] ? ~sym[7:0] : sym[7:0];
    byte_in  = {d_in[7:1] ^ d_in[6:0] ^ {7{~sym[8]}}, d_in[0]};
    is_ctrl  = sym == 10'h354 || sym == 10'h0AB || sym == 10'h154 || sym == 10'h2AB;
    tok_in   = sym == 10'h0AB ? 2'b01 : sym == 10'h154 ? 2'b10 : sym == 10'h2AB ? 2'b11 : 2'b00;
    xnor_req = $countones(byte_in) > 4 || ($countones(byte_in) == 4 && !byte_in[0]);
    cls_in   = is_ctrl ? CLS_CTRL : (sym[8] == xnor_req) ? CLS_ERR : CLS_DATA;
  end
  logic       s1_valid_q;
  logic [7:0] s1_byte_q;
  logic [1:0] s1_tok_q;
  cls_t       s1_cls_q;
  always_ff @(posedge clk_h) begin
    if (rst_h) begin
      s1_valid_q <= 1'b0;
      s1_byte_q  <= '0;
      s1_tok_q   <= '0;
      s1_cls_q   <= CLS_DATA;
    end else begin
      s1_valid_q <= sym_valid;
      if (sym_valid) begin
        s1_byte_q <= byte_in;
        s1_tok_q  <= tok_in;
        s1_cls_q  <= cls_in;
      end
    end
  end
  logic cv, cc, ce;
  assign cv = s1_valid_q;
  assign cc = s1_valid_q && s1_cls_q == CLS_CTRL;
  assign ce = s1_valid_q && s1_cls_q == CLS_ERR;
  state_t          state_q, state_d;
  logic [RW-1:0]   ctrl_run_q, ctrl_run_d;
  logic [SW-1:0]   search_cnt_q, search_cnt_d;
  logic [TW-1:0]   settle_q, settle_d;
  logic [WW-1:0]   win_cnt_q, win_cnt_d;
  logic [EW-1:0]   win_err_q, win_err_d;
  logic            locked_d, bitslip_d;
  always_ff @(posedge clk_h) begin
    if (rst_h) begin
      state_q      <= SEARCH;
      ctrl_run_q   <= '0;
      search_cnt_q <= '0;
      settle_q     <= '0;
      win_cnt_q    <= '0;
      win_err_q    <= '0;
    end else begin
      state_q      <= state_d;
      ctrl_run_q   <= ctrl_run_d;
      search_cnt_q <= search_cnt_d;
      settle_q     <= settle_d;
      win_cnt_q    <= win_cnt_d;
      win_err_q    <= win_err_d;
    end
  end
  always_comb begin
    state_d      = state_q;
    ctrl_run_d   = ctrl_run_q;
    search_cnt_d = search_cnt_q;
    settle_d     = settle_q;
    win_cnt_d    = win_cnt_q;
    win_err_d    = win_err_q;
    case (state_q)
      SLIP: begin
        settle_d = settle_q + TW'(1);
        if (settle_q == SETTLE_LAST) begin
          state_d      = SEARCH;
          ctrl_run_d   = '0;
          search_cnt_d = '0;
        end
      end
      LOCKED: if (cv) begin
        win_cnt_d = win_cnt_q + WW'(1);
        win_err_d = ce ? win_err_q + EW'(1) : win_err_q;
        if (ce && win_err_q == ERR_LAST) begin
          state_d      = SEARCH;
          win_cnt_d    = '0;
          win_err_d    = '0;
          ctrl_run_d   = '0;
          search_cnt_d = '0;
        end else if (win_cnt_q == WIN_LAST) begin
          win_cnt_d = '0;
          win_err_d = '0;
        end
      end
      default: if (cv) begin
        ctrl_run_d   = cc ? ctrl_run_q + RW'(1) : '0;
        search_cnt_d = search_cnt_q + SW'(1);
        if (cc && ctrl_run_q == RUN_LAST) begin
          state_d      = LOCKED;
          win_cnt_d    = '0;
          win_err_d    = '0;
          ctrl_run_d   = '0;
          search_cnt_d = '0;
        end else if (search_cnt_q == SEARCH_LAST) begin
          state_d  = SLIP;
          settle_d = '0;
        end
      end
    endcase
  end
  always_comb begin
    locked_d  = state_d == LOCKED;
    bitslip_d = state_q != SLIP && state_d == SLIP;
  end
  logic        out_valid_q, de_q, sym_err_q, locked_q, bitslip_q;
  logic [7:0]  data_q;
  logic [1:0]  ctrl_q;
  logic [15:0] err_count_q;
  always_ff @(posedge clk_h) begin
    if (rst_h) begin
      out_valid_q <= 1'b0;
      data_q      <= '0;
      ctrl_q      <= '0;
      de_q        <= 1'b0;
      sym_err_q   <= 1'b0;
      locked_q    <= 1'b0;
      bitslip_q   <= 1'b0;
      err_count_q <= '0;
    end else begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        data_q <= cc ? 8'h00 : s1_byte_q;
        ctrl_q <= cc ? s1_tok_q : ctrl_q;
      end
      de_q        <= cv && !cc && locked_d;
      sym_err_q   <= ce;
      locked_q    <= locked_d;
      bitslip_q   <= bitslip_d;
      err_count_q <= (ce && err_count_q != 16'hFFFF) ? err_count_q + 16'd1 : err_count_q;
    end
  end
  assign out_valid = out_valid_q;
  assign data      = data_q;
  assign ctrl      = ctrl_q;
  assign de        = de_q;
  assign sym_err   = sym_err_q;
  assign locked    = locked_q;
  assign bitslip   = bitslip_q;
  assign err_count = err_count_q;
endmodule

// File: tb/tb_tmds_channel_decoder.sv
// tb_tmds_channel_decoder: scoreboard bench for the TMDS channel decoder.
module tb_tmds_channel_decoder;
  logic        clk_h = 1'b0, rst_h = 1'b1, sym_valid = 1'b0;
  logic [9:0]  sym = '0;
  logic        out_valid, de, sym_err, locked, bitslip;
  logic [7:0]  data;
  logic [1:0]  ctrl;
  logic [15:0] err_count;
  tmds_channel_decoder dut (
    .clk_h(clk_h), .rst_h(rst_h), .sym_valid(sym_valid), .sym(sym),
    .out_valid(out_valid), .data(data), .ctrl(ctrl), .de(de), .sym_err(sym_err),
    .locked(locked), .bitslip(bitslip), .err_count(err_count)
  );
  always #5 clk_h = ~clk_h;
  typedef struct packed {
    logic [7:0] d;
    logic [1:0] c;
    logic       e;
    logic       de;
    logic       chk_de;
  } exp_t;
  exp_t       sb[$];
  int         n_chk = 0, n_fail = 0;
  logic [1:0] vh;
  logic       m_lock = 1'b0, m_known = 1'b0;
  logic [1:0] m_ctrl = 2'b00;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] dec(input logic [9:0] q);
    logic [7:0] d, o;
    d = q[9] ? ~q[7:0] : q[7:0];
    o[0] = d[0];
    for (int i = 1; i < 8; i++) o[i] = q[8] ? d[i] ^ d[i-1] : ~(d[i] ^ d[i-1]);
    return o;
  endfunction
  function automatic logic [2:0] ctl(input logic [9:0] q);
    case (q)
      10'h354: return 3'b100;
      10'h0AB: return 3'b101;
      10'h154: return 3'b110;
      10'h2AB: return 3'b111;
      default: return 3'b000;
    endcase
  endfunction
  task automatic step(input logic v, input logic [9:0] s);
    exp_t e;
    logic [2:0] c;
    logic [7:0] b;
    int ones;
    sym_valid = v;
    sym = s;
    if (v) begin
      c = ctl(s);
      b = dec(s);
      ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(b[i]);
      if (c[2]) m_ctrl = c[1:0];
      e.d = c[2] ? 8'h00 : b;
      e.c = m_ctrl;
      e.e = !c[2] && (s[8] == (ones > 4 || (ones == 4 && !b[0])));
      e.de = !c[2] && m_lock;
      e.chk_de = m_known && !e.e;
      sb.push_back(e);
    end
    @(posedge clk_h);
    #1;
  endtask
  task automatic do_reset(input int n);
    rst_h = 1'b1;
    sym_valid = 1'b0;
    repeat (n) @(posedge clk_h);
    #1;
    rst_h = 1'b0;
    sb.delete();
    m_ctrl = 2'b00;
    m_lock = 1'b0;
    m_known = 1'b1;
  endtask
  task automatic lock_up();
    m_lock = 1'b0;
    m_known = 1'b1;
    repeat (16) step(1'b1, 10'h354);
    step(1'b0, 10'h000);
    step(1'b0, 10'h000);
    m_lock = 1'b1;
  endtask
  always @(posedge clk_h) vh <= rst_h ? 2'b00 : {vh[0], sym_valid};
  always @(negedge clk_h) begin : mon
    exp_t e;
    if (!rst_h) begin
      chk("out_valid", 32'(out_valid), 32'(vh[1]));
      if (!out_valid) begin
        chk("de_idle", 32'(de), 0);
        chk("err_idle", 32'(sym_err), 0);
      end else if (sb.size() == 0) begin
        chk("sb_nonempty", 32'(sb.size()), 1);
      end else begin
        e = sb.pop_front();
        chk("data", 32'(data), 32'(e.d));
        chk("ctrl", 32'(ctrl), 32'(e.c));
        chk("sym_err", 32'(sym_err), 32'(e.e));
        if (e.chk_de) chk("de", 32'(de), 32'(e.de));
      end
    end
  end
  initial begin
    int np, p1, p2;
    do_reset(3);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_bitslip", 32'(bitslip), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_data", 32'(data), 0);
    chk("rst_ctrl", 32'(ctrl), 0);
    chk("rst_de", 32'(de), 0);
    chk("rst_sym_err", 32'(sym_err), 0);
    chk("rst_err_count", 32'(err_count), 0);
    repeat (15) step(1'b1, 10'h354);
    step(1'b1, 10'h100);
    repeat (3) step(1'b0, 10'h000);
    chk("no_lock_15", 32'(locked), 0);
    repeat (16) step(1'b1, 10'h354);
    chk("lock_not_early", 32'(locked), 0);
    step(1'b0, 10'h000);
    chk("lock_2cyc", 32'(locked), 1);
    chk("lock_out_valid", 32'(out_valid), 1);
    chk("lock_ctrl", 32'(ctrl), 0);
    chk("lock_de", 32'(de), 0);
    step(1'b0, 10'h000);
    m_lock = 1'b1;
    step(1'b1, 10'h100);
    step(1'b1, 10'h200);
    step(1'b1, 10'h000);
    step(1'b1, 10'h0AB);
    step(1'b1, 10'h155);
    repeat (3) step(1'b0, 10'h000);
    chk("dec_err_count", 32'(err_count), 1);
    chk("dec_locked", 32'(locked), 1);
    rst_h = 1'b1;
    sym_valid = 1'b0;
    @(posedge clk_h);
    #1;
    chk("midrst_locked", 32'(locked), 0);
    do_reset(2);
    lock_up();
    chk("loss_pre_locked", 32'(locked), 1);
    repeat (8) begin
      step(1'b1, 10'h155);
      chk("loss_bitslip", 32'(bitslip), 0);
    end
    chk("loss_hold", 32'(locked), 1);
    step(1'b0, 10'h000);
    chk("loss_locked", 32'(locked), 0);
    chk("loss_bitslip_end", 32'(bitslip), 0);
    m_lock = 1'b0;
    repeat (2) step(1'b0, 10'h000);
    chk("loss_err_count", 32'(err_count), 8);
    do_reset(2);
    lock_up();
    repeat (7) step(1'b1, 10'h155);
    repeat (1017) step(1'b1, 10'h100);
    step(1'b1, 10'h155);
    repeat (3) step(1'b0, 10'h000);
    chk("wrap_locked", 32'(locked), 1);
    chk("wrap_err_count", 32'(err_count), 8);
    do_reset(2);
    np = 0;
    p1 = -1;
    p2 = -1;
    for (int i = 0; i < 4110; i++) begin
      step(1'b1, 10'h100);
      if (bitslip) begin
        if (np == 0) p1 = i;
        else if (np == 1) p2 = i;
        np++;
      end
    end
    chk("slip_pulses", 32'(np), 2);
    chk("slip_first", 32'(p1), 2048);
    chk("slip_second", 32'(p2), 4104);
    chk("slip_locked", 32'(locked), 0);
    do_reset(2);
    repeat (16) begin
      step(1'b1, 10'h354);
      step(1'b0, 10'h000);
    end
    step(1'b0, 10'h000);
    chk("gap_locked", 32'(locked), 1);
    repeat (3) step(1'b0, 10'h000);
    chk("sb_drained", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
